riscv_hart: RTL and testbench

Single-issue, in-order RV32I integer core (subset) with a three-stage internal pipeline (decode/execute, memory, writeback). It connects to an external synchronous instruction memory and a synchronous data memory, each with one cycle of read latency. The hart has no hazard detection and no forwarding; software must schedule around dependencies.

---
 rtl/riscv_hart.sv | 203 ++++++++++++++++++++
 tb/tb_riscv_hart.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_hart.sv
// RV32I integer subset hart: combinational decode/execute on the fetched word,
// then EX/MEM and MEM/WB registers; no interlocks, software spaces dependencies.
module riscv_hart #(
    parameter int XLEN   = 32,
    parameter int AWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instruction,
    output logic [AWIDTH-1:0] pc,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_data,
    output logic              mem_write,
    input  logic [XLEN-1:0]   mem_read
);

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_t;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    logic [AWIDTH-1:0] pc_prev;
    logic              fetch_vld;
    logic [XLEN-1:0]   regs [32];

    logic [6:0]      opcode, funct7;
    logic [4:0]      rd, rs1, rs2, shamt;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_val, rs2_val, imm_i, imm_s, imm_u;
    logic [XLEN-1:0] op_a, op_b, alu_y;
    alu_op_t         alu_op;
    logic            dec_wen, dec_ld, dec_st;

    logic [XLEN-1:0] ex_result, ex_store_data;
    logic [4:0]      ex_rd;
    logic            ex_wen, ex_ld, ex_st;
    logic [XLEN-1:0] wb_result;
    logic [4:0]      wb_rd;
    logic            wb_wen, wb_ld;

    assign opcode = instruction[6:0];
    assign rd     = instruction[11:7];
    assign funct3 = instruction[14:12];
    assign rs1    = instruction[19:15];
    assign rs2    = instruction[24:20];
    assign funct7 = instruction[31:25];

    assign imm_i = XLEN'($signed(instruction[31:20]));
    assign imm_s = XLEN'($signed({instruction[31:25], instruction[11:7]}));
    assign imm_u = XLEN'($signed({instruction[31:12], 12'b0}));

    assign rs1_val = (rs1 == 5'd0) ? '0 : regs[rs1];
    assign rs2_val = (rs2 == 5'd0) ? '0 : regs[rs2];

    always_comb begin
        op_a    = rs1_val;
        op_b    = imm_i;
        alu_op  = ALU_ADD;
        dec_wen = 1'b0;
        dec_ld  = 1'b0;
        dec_st  = 1'b0;
        case (opcode)
            OPC_OP_IMM: begin
                dec_wen = 1'b1;
                case (funct3)
                    3'b010:  alu_op = ALU_SLT;
                    3'b011:  alu_op = ALU_SLTU;
                    3'b100:  alu_op = ALU_XOR;
                    3'b110:  alu_op = ALU_OR;
                    3'b111:  alu_op = ALU_AND;
                    3'b001: begin
                        alu_op  = ALU_SLL;
                        dec_wen = (funct7 == 7'b0000000);
                    end
                    3'b101: begin
                        alu_op  = funct7[5] ? ALU_SRA : ALU_SRL;
                        dec_wen = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                    end
                    default: alu_op = ALU_ADD;
                endcase
            end
            OPC_OP: begin
                op_b    = rs2_val;
                dec_wen = 1'b1;
                case ({funct7, funct3})
                    {7'h00, 3'b000}: alu_op = ALU_ADD;
                    {7'h20, 3'b000}: alu_op = ALU_SUB;
                    {7'h00, 3'b001}: alu_op = ALU_SLL;
                    {7'h00, 3'b010}: alu_op = ALU_SLT;
                    {7'h00, 3'b011}: alu_op = ALU_SLTU;
                    {7'h00, 3'b100}: alu_op = ALU_XOR;
                    {7'h00, 3'b101}: alu_op = ALU_SRL;
                    {7'h20, 3'b101}: alu_op = ALU_SRA;
                    {7'h00, 3'b110}: alu_op = ALU_OR;
                    {7'h00, 3'b111}: alu_op = ALU_AND;
                    default:         dec_wen = 1'b0;
                endcase
            end
            OPC_LUI: begin
                op_a    = '0;
                op_b    = imm_u;
                dec_wen = 1'b1;
            end
            OPC_AUIPC: begin
                op_a    = XLEN'(pc_prev);
                op_b    = imm_u;
                dec_wen = 1'b1;
            end
            OPC_LOAD: begin
                dec_wen = (funct3 == 3'b010);
                dec_ld  = (funct3 == 3'b010);
            end
            OPC_STORE: begin
                op_b   = imm_s;
                dec_st = (funct3 == 3'b010);
            end
            default: dec_wen = 1'b0;
        endcase
        // The word on the bus during reset is not a fetched instruction
        if (!fetch_vld) begin
            dec_wen = 1'b0;
            dec_ld  = 1'b0;
            dec_st  = 1'b0;
        end
        if (rd == 5'd0) dec_wen = 1'b0;
    end

    always_comb begin
        shamt = op_b[4:0];
        alu_y = '0;
        case (alu_op)
            ALU_ADD:  alu_y = op_a + op_b;
            ALU_SUB:  alu_y = op_a - op_b;
            ALU_SLL:  alu_y = op_a << shamt;
            ALU_SLT:  alu_y = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            ALU_SLTU: alu_y = {{(XLEN-1){1'b0}}, op_a < op_b};
            ALU_XOR:  alu_y = op_a ^ op_b;
            ALU_SRL:  alu_y = op_a >> shamt;
            ALU_SRA:  alu_y = $unsigned($signed(op_a) >>> shamt);
            ALU_OR:   alu_y = op_a | op_b;
            ALU_AND:  alu_y = op_a & op_b;
            default:  alu_y = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= '0;
            pc_prev   <= '0;
            fetch_vld <= 1'b0;
        end else begin
            pc        <= pc + AWIDTH'(4);
            pc_prev   <= pc;
            fetch_vld <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_result     <= '0;
            ex_store_data <= '0;
            ex_rd         <= '0;
            ex_wen        <= 1'b0;
            ex_ld         <= 1'b0;
            ex_st         <= 1'b0;
            wb_result     <= '0;
            wb_rd         <= '0;
            wb_wen        <= 1'b0;
            wb_ld         <= 1'b0;
        end else begin
            ex_result     <= alu_y;
            ex_store_data <= rs2_val;
            ex_rd         <= rd;
            ex_wen        <= dec_wen;
            ex_ld         <= dec_ld;
            ex_st         <= dec_st;
            wb_result     <= ex_result;
            wb_rd         <= ex_rd;
            wb_wen        <= ex_wen;
            wb_ld         <= ex_ld;
        end
    end

    assign mem_addr  = AWIDTH'(ex_result);
    assign mem_data  = ex_store_data;
    assign mem_write = ex_st;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 32; k++) regs[k] <= '0;
        end else if (wb_wen) begin
            regs[wb_rd] <= wb_ld ? mem_read : wb_result;
        end
    end

endmodule

// File: tb/tb_riscv_hart.sv
// Bench for riscv_hart: directed and random programs run against a sequential
// ISA model whose register writes become visible three instructions later.
module tb_riscv_hart;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instruction;
    logic [31:0] pc, mem_addr, mem_data, mem_read;
    logic        mem_write;

    riscv_hart #(.XLEN(32), .AWIDTH(32)) dut (
        .clk(clk), .rst(rst), .instruction(instruction), .pc(pc),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_write(mem_write),
        .mem_read(mem_read)
    );

    always #5 clk = ~clk;

    logic [31:0] imem [64];
    logic [31:0] dmem [64];
    logic [31:0] mdm  [64];

    always @(posedge clk) begin
        instruction <= imem[pc[7:2]];
        mem_read    <= dmem[mem_addr[7:2]];
        if (mem_write) dmem[mem_addr[7:2]] <= mem_data;
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } st_t;
    st_t exp_q[$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && mem_write) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_store: got addr %h data %h expected none", mem_addr, mem_data);
            end else begin
                st_t e;
                e = exp_q.pop_front();
                chk("store_addr", mem_addr, e.addr);
                chk("store_data", mem_data, e.data);
            end
        end
    end

    function automatic logic [31:0] e_i(input logic [6:0] opc, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [31:0] imm);
        return {imm[11:0], rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] e_r(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] e_s(input logic [2:0] f3, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [31:0] imm);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] e_u(input logic [6:0] opc, input logic [4:0] rd,
                                        input logic [31:0] imm20);
        return {imm20[19:0], rd, opc};
    endfunction

    // Sequential execution; a result is committed just before instruction i+3 runs.
    task automatic model_run(input int n);
        logic [31:0] m [32];
        logic [31:0] pv [64];
        logic [4:0]  prd [64];
        logic        pen [64];
        logic [31:0] w, a, b, ii, si, r, ea;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic        we;
        st_t         s;
        for (int k = 0; k < 32; k++) m[k] = 0;
        for (int i = 0; i < n; i++) begin
            if (i >= 3 && pen[i-3]) m[prd[i-3]] = pv[i-3];
            w  = imem[i];
            a  = m[w[19:15]];
            b  = m[w[24:20]];
            f3 = w[14:12];
            f7 = w[31:25];
            ii = {{20{w[31]}}, w[31:20]};
            si = {{20{w[31]}}, w[31:25], w[11:7]};
            we = 1'b0;
            r  = 0;
            case (w[6:0])
                7'h13: begin
                    we = 1'b1;
                    case (f3)
                        3'd0: r = a + ii;
                        3'd2: r = ($signed(a) < $signed(ii)) ? 1 : 0;
                        3'd3: r = (a < ii) ? 1 : 0;
                        3'd4: r = a ^ ii;
                        3'd6: r = a | ii;
                        3'd7: r = a & ii;
                        3'd1: begin r = a << ii[4:0]; we = (f7 == 7'h00); end
                        default: begin
                            if (f7 == 7'h00) r = a >> ii[4:0];
                            else if (f7 == 7'h20) r = $signed(a) >>> ii[4:0];
                            else we = 1'b0;
                        end
                    endcase
                end
                7'h33: begin
                    we = 1'b1;
                    case ({f7, f3})
                        {7'h00, 3'd0}: r = a + b;
                        {7'h20, 3'd0}: r = a - b;
                        {7'h00, 3'd1}: r = a << b[4:0];
                        {7'h00, 3'd2}: r = ($signed(a) < $signed(b)) ? 1 : 0;
                        {7'h00, 3'd3}: r = (a < b) ? 1 : 0;
                        {7'h00, 3'd4}: r = a ^ b;
                        {7'h00, 3'd5}: r = a >> b[4:0];
                        {7'h20, 3'd5}: r = $signed(a) >>> b[4:0];
                        {7'h00, 3'd6}: r = a | b;
                        {7'h00, 3'd7}: r = a & b;
                        default: we = 1'b0;
                    endcase
                end
                7'h37: begin we = 1'b1; r = w & 32'hFFFF_F000; end
                7'h17: begin we = 1'b1; r = 4 * i + (w & 32'hFFFF_F000); end
                7'h03: if (f3 == 3'd2) begin
                    we = 1'b1;
                    ea = a + ii;
                    r  = mdm[ea[7:2]];
                end
                7'h23: if (f3 == 3'd2) begin
                    ea = a + si;
                    mdm[ea[7:2]] = b;
                    s.addr = ea;
                    s.data = b;
                    exp_q.push_back(s);
                end
                default: we = 1'b0;
            endcase
            pen[i] = we && (w[11:7] != 5'd0);
            prd[i] = w[11:7];
            pv[i]  = r;
        end
    endtask

    task automatic run_prog(input int n);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 64; k++) begin
            dmem[k] = 32'hDEAD_0000 | k;
            mdm[k]  = 32'hDEAD_0000 | k;
        end
        model_run(n);
        repeat (3) begin
            @(negedge clk);
            chk("reset_pc", pc, 0);
            chk("reset_mem_write", {31'b0, mem_write}, 0);
            chk("reset_mem_addr", mem_addr, 0);
        end
        rst = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            @(posedge clk);
            #1 chk("pc_after_release", pc, 4 * j);
        end
        repeat (n + 6) @(posedge clk);
        @(negedge clk);
        chk("stores_drained", exp_q.size(), 0);
        exp_q.delete();
        for (int k = 0; k < 64; k++) chk("dmem_word", dmem[k], mdm[k]);
    endtask

    task automatic clear_imem();
        for (int k = 0; k < 64; k++) imem[k] = 32'h0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [31:0] imm;
        rd  = 5'($urandom_range(0, 7));
        rs1 = 5'($urandom_range(0, 7));
        rs2 = 5'($urandom_range(0, 7));
        f3  = 3'($urandom_range(0, 7));
        imm = $urandom_range(0, 4095);
        case ($urandom_range(0, 7))
            0: begin
                if (f3 == 3'd1) imm = {20'b0, 7'h00, imm[4:0]};
                if (f3 == 3'd5) imm = {20'b0, ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, imm[4:0]};
                return e_i(7'h13, f3, rd, rs1, imm);
            end
            1: return e_r(((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00,
                          f3, rd, rs1, rs2);
            2: return e_u(7'h37, rd, $urandom());
            3: return e_u(7'h17, rd, $urandom());
            4: return e_i(7'h03, 3'd2, rd, 5'd0, 4 * $urandom_range(0, 15));
            5, 6: return e_s(3'd2, rs2, 5'd0, 4 * $urandom_range(0, 15));
            default: begin
                case ($urandom_range(0, 3))
                    0: return 32'h0;
                    1: return {$urandom_range(0, 33554431), 7'h63} & 32'hFFFF_FFFF;
                    2: return e_i(7'h03, 3'd0, rd, 5'd0, 4 * $urandom_range(0, 15));
                    default: return e_s(3'd0, rs2, 5'd0, 4 * $urandom_range(0, 15));
                endcase
            end
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 64; k++) dmem[k] = 0;
        clear_imem();

        // Basic store program
        imem[0] = e_i(7'h13, 3'd0, 5'd5, 5'd0, 42);
        imem[1] = e_i(7'h13, 3'd0, 5'd1, 5'd0, 77);
        imem[5] = e_s(3'd2, 5'd5, 5'd0, 12);
        imem[6] = e_s(3'd2, 5'd1, 5'd0, 8);
        run_prog(7);
        chk("word3_42", dmem[3], 32'd42);
        chk("word2_77", dmem[2], 32'd77);

        // ALU coverage
        clear_imem();
        imem[0]  = e_i(7'h13, 3'd0, 5'd1, 5'd0, 1);
        imem[1]  = e_i(7'h13, 3'd0, 5'd2, 5'd0, -5);
        imem[4]  = e_r(7'h20, 3'd0, 5'd3, 5'd2, 5'd1);
        imem[5]  = e_i(7'h13, 3'd0, 5'd4, 5'd0, 2);
        imem[6]  = e_r(7'h00, 3'd3, 5'd10, 5'd0, 5'd2);
        imem[7]  = e_s(3'd2, 5'd2, 5'd0, 0);
        imem[8]  = e_r(7'h20, 3'd5, 5'd11, 5'd2, 5'd4);
        imem[9]  = e_s(3'd2, 5'd3, 5'd0, 4);
        imem[10] = e_s(3'd2, 5'd10, 5'd0, 8);
        imem[11] = e_s(3'd2, 5'd11, 5'd0, 12);
        run_prog(12);
        chk("addi_neg5", dmem[0], 32'hFFFF_FFFB);
        chk("sub", dmem[1], 32'hFFFF_FFFA);
        chk("sltu", dmem[2], 32'd1);
        chk("sra", dmem[3], 32'hFFFF_FFFE);

        // Load-use, LUI/AUIPC, x0 and stale-read hazard
        clear_imem();
        imem[0]  = e_u(7'h37, 5'd1, 1);
        imem[3]  = e_i(7'h13, 3'd0, 5'd1, 5'd1, 32'h234);
        imem[6]  = e_s(3'd2, 5'd1, 5'd0, 16);
        imem[9]  = e_i(7'h03, 3'd2, 5'd6, 5'd0, 16);
        imem[12] = e_s(3'd2, 5'd6, 5'd0, 20);
        imem[13] = e_u(7'h37, 5'd7, 32'hABCDE);
        imem[14] = e_u(7'h17, 5'd8, 1);
        imem[15] = e_i(7'h13, 3'd0, 5'd0, 5'd0, 99);
        imem[16] = e_i(7'h13, 3'd0, 5'd9, 5'd0, 55);
        imem[18] = e_s(3'd2, 5'd7, 5'd0, 24);
        imem[19] = e_s(3'd2, 5'd8, 5'd0, 28);
        imem[20] = e_s(3'd2, 5'd0, 5'd0, 0);
        imem[21] = e_i(7'h13, 3'd0, 5'd9, 5'd0, 66);
        imem[23] = e_s(3'd2, 5'd9, 5'd0, 32);
        run_prog(24);
        chk("load_use", dmem[5], 32'h1234);
        chk("lui", dmem[6], 32'hABCD_E000);
        chk("auipc", dmem[7], 32'd56 + 32'h1000);
        chk("x0_zero", dmem[0], 32'd0);
        chk("stale_read", dmem[8], 32'd55);

        // Random programs
        for (int p = 0; p < 20; p++) begin
            clear_imem();
            for (int k = 0; k < 40; k++) imem[k] = rand_instr();
            run_prog(40);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
